// File: rtl/tx_os_generator.sv
// Transmit-side ordered-set generator for the LTSSM.
// Builds TS1/TS2 ordered sets for every lane slot from the configuration latched on start,
// offers them on a valid/ready handshake and counts accepted sets against the minimum
// transmit count of the current substate.
// Optional build macro TX_EIEOS_INSERT_EN: at gen 3, one EIEOS is sent before the first TS
// and after every 32 accepted TS sets (EIEOS is not counted).
module tx_os_generator #(
    parameter int unsigned DEVICETYPE = 0,
    parameter int unsigned LANES      = 16,
    parameter logic [7:0]  NFTS       = 8'd255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             substate,
    input  logic                   start,
    input  logic                   stop,
    input  logic [2:0]             gen,
    input  logic [7:0]             linkNumber,
    input  logic [4:0]             numberOfDetectedLanes,
    input  logic [7:0]             rateId,
    input  logic [7:0]             trainingCtrl,
    output logic [LANES*128-1:0]   orderedSets,
    output logic                   osValid,
    input  logic                   osReady,
    output logic                   minSentDone,
    output logic [10:0]            sentCount,
    output logic                   busy
);

    localparam logic [7:0] Pad = 8'hF7;

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StDrain} state_e;

    state_e               stateQ, stateD;
    logic [4:0]           subQ;
    logic [LANES*128-1:0] tsSetQ;
    logic [LANES*128-1:0] buildSet;
    logic [10:0]          sentCountQ;
    logic                 minDoneQ;
    logic                 subValid;
    logic                 isTs2;
    logic                 useLink;
    logic                 laneNumbered;
    logic [10:0]          minCount;
    logic                 sending;
    logic                 eieosActive;
    logic                 accept;

    assign subValid = substate inside {5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd11, 5'd13};
    assign sending  = (stateQ == StSend) || (stateQ == StDrain);
    // EIEOS handshakes do not advance the TS count
    assign accept   = sending && osReady && !eieosActive;

    // Decode the latched substate into set type, link/lane policy and minimum count
    always_comb begin
        isTs2        = 1'b0;
        useLink      = 1'b0;
        laneNumbered = 1'b0;
        minCount     = 11'd1;
        case (subQ)
            5'd2: minCount = 11'd1024;
            5'd3: begin
                isTs2    = 1'b1;
                minCount = 11'd16;
            end
            // Configuration link/lane numbers come only from a downstream port
            5'd4: useLink = (DEVICETYPE != 0);
            5'd5: begin
                useLink      = (DEVICETYPE != 0);
                laneNumbered = 1'b1;
            end
            5'd6: begin
                isTs2        = 1'b1;
                useLink      = (DEVICETYPE != 0);
                laneNumbered = 1'b1;
                minCount     = 11'd16;
            end
            5'd11: begin
                useLink      = 1'b1;
                laneNumbered = 1'b1;
            end
            5'd13: begin
                isTs2        = 1'b1;
                useLink      = 1'b1;
                laneNumbered = 1'b1;
                minCount     = 11'd16;
            end
            default: ;
        endcase
    end

    // Assemble one TS1/TS2 per lane from the live configuration inputs (captured in LOAD)
    always_comb begin
        buildSet = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            logic linked;
            linked = useLink && (i < int'(numberOfDetectedLanes));
            buildSet[i*128 +: 8]      = (gen == 3'd3) ? (isTs2 ? 8'h2D : 8'h1E) : 8'hBC;
            buildSet[i*128 + 8 +: 8]  = linked ? linkNumber : Pad;
            buildSet[i*128 + 16 +: 8] = (linked && laneNumbered) ? 8'(i) : Pad;
            buildSet[i*128 + 24 +: 8] = NFTS;
            buildSet[i*128 + 32 +: 8] = rateId;
            buildSet[i*128 + 40 +: 8] = trainingCtrl;
            for (int k = 6; k < 16; k++) begin
                buildSet[i*128 + k*8 +: 8] = isTs2 ? 8'h45 : 8'h4A;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // FSM next state; a simultaneous stop suppresses start
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StIdle:  if (start && !stop && subValid) stateD = StLoad;
            StLoad:  stateD = StSend;
            StSend:  if (stop) stateD = osReady ? StIdle : StDrain;
            StDrain: if (osReady) stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    // Configuration capture, set storage and accepted-set accounting
    always_ff @(posedge clk) begin
        if (reset) begin
            subQ       <= '0;
            tsSetQ     <= '0;
            sentCountQ <= '0;
            minDoneQ   <= 1'b0;
        end else begin
            if (stateQ == StIdle && stateD == StLoad) begin
                subQ <= substate;
            end
            if (stateQ == StLoad) begin
                tsSetQ     <= buildSet;
                sentCountQ <= '0;
                minDoneQ   <= 1'b0;
            end else if (accept) begin
                if (sentCountQ != 11'h7FF) begin
                    sentCountQ <= sentCountQ + 11'd1;
                end
                if (sentCountQ + 11'd1 == minCount) begin
                    minDoneQ <= 1'b1;
                end
            end
        end
    end

`ifdef TX_EIEOS_INSERT_EN
    logic       eieosPendQ;
    logic       genIs3Q;
    logic [4:0] tsRunQ;
    logic [LANES*128-1:0] eieosSet;

    // EIEOS scheduling: one up front, then one after each run of 32 accepted TS sets
    always_ff @(posedge clk) begin
        if (reset) begin
            eieosPendQ <= 1'b0;
            genIs3Q    <= 1'b0;
            tsRunQ     <= '0;
        end else if (stateQ == StLoad) begin
            eieosPendQ <= (gen == 3'd3);
            genIs3Q    <= (gen == 3'd3);
            tsRunQ     <= '0;
        end else if (sending && osReady) begin
            if (eieosPendQ) begin
                eieosPendQ <= 1'b0;
            end else if (genIs3Q) begin
                tsRunQ <= tsRunQ + 5'd1;
                if (tsRunQ == 5'd31) begin
                    eieosPendQ <= 1'b1;
                end
            end
        end
    end

    assign eieosActive = eieosPendQ && sending;

    // EIEOS pattern: symbols alternate 0x00 / 0xFF starting with 0x00
    always_comb begin
        eieosSet = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            for (int k = 1; k < 16; k += 2) begin
                eieosSet[i*128 + k*8 +: 8] = 8'hFF;
            end
        end
    end
`else
    assign eieosActive = 1'b0;
`endif

    // FSM outputs and status
    always_comb begin
        osValid     = sending;
        busy        = sending;
        sentCount   = sentCountQ;
        minSentDone = minDoneQ;
        orderedSets = tsSetQ;
`ifdef TX_EIEOS_INSERT_EN
        if (eieosActive) orderedSets = eieosSet;
`endif
    end

endmodule

// File: tb/tb_tx_os_generator.sv
// Self-checking bench for tx_os_generator: table-driven vectors, hand-written corner
// sequences and randomized runs checked against a behavioural model every cycle.
module tb_tx_os_generator;

    localparam int unsigned DevType = 1;
    localparam logic [7:0]  Pad     = 8'hF7;
`ifdef TX_EIEOS_INSERT_EN
    localparam bit EieosEn = 1'b1;
`else
    localparam bit EieosEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    substate = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [2:0]    gen = 3'd1;
    logic [7:0]    linkNumber = '0;
    logic [4:0]    numberOfDetectedLanes = '0;
    logic [7:0]    rateId = '0;
    logic [7:0]    trainingCtrl = '0;
    logic [2047:0] orderedSets;
    logic          osValid;
    logic          osReady = 1'b0;
    logic          minSentDone;
    logic [10:0]   sentCount;
    logic          busy;

    tx_os_generator #(
        .DEVICETYPE(DevType),
        .LANES     (16),
        .NFTS      (8'd255)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .substate             (substate),
        .start                (start),
        .stop                 (stop),
        .gen                  (gen),
        .linkNumber           (linkNumber),
        .numberOfDetectedLanes(numberOfDetectedLanes),
        .rateId               (rateId),
        .trainingCtrl         (trainingCtrl),
        .orderedSets          (orderedSets),
        .osValid              (osValid),
        .osReady              (osReady),
        .minSentDone          (minSentDone),
        .sentCount            (sentCount),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic [2:0] gen;
        logic [7:0] link;
        logic [4:0] nDet;
        logic [7:0] rate;
        logic [7:0] tc;
    } cfgT;

    // Behavioural model state
    bit            mLoad, mActive, mStopping, mDone;
    int            p;           // accepted handshakes (TS and EIEOS) in this run
    logic [4:0]    mSub;
    cfgT           mCfg;
    logic [2047:0] mLastTs;

    function automatic int minOf(input logic [4:0] s);
        case (s)
            5'd2:  return 1024;
            5'd3:  return 16;
            5'd4:  return 1;
            5'd5:  return 1;
            5'd6:  return 16;
            5'd11: return 1;
            5'd13: return 16;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2047:0] modelTs(input logic [4:0] s, input cfgT c);
        logic [2047:0] r;
        bit ts2, linked;
        logic [7:0] v;
        r = '0;
        ts2 = (s == 5'd3) || (s == 5'd6) || (s == 5'd13);
        for (int lane = 0; lane < 16; lane++) begin
            linked = ((s >= 5'd4 && s <= 5'd6 && DevType == 1) || s == 5'd11 || s == 5'd13)
                     && (lane < int'(c.nDet));
            for (int k = 0; k < 16; k++) begin
                case (k)
                    0: v = (c.gen == 3'd3) ? (ts2 ? 8'h2D : 8'h1E) : 8'hBC;
                    1: v = linked ? c.link : Pad;
                    2: v = (linked && s != 5'd4) ? 8'(lane) : Pad;
                    3: v = 8'hFF;
                    4: v = c.rate;
                    5: v = c.tc;
                    default: v = ts2 ? 8'h45 : 8'h4A;
                endcase
                r[lane*128 + k*8 +: 8] = v;
            end
        end
        return r;
    endfunction

    function automatic logic [2047:0] eieosPattern();
        logic [2047:0] r;
        for (int i = 0; i < 128; i++) r[i*16 +: 16] = 16'hFF00;
        return r;
    endfunction

    function automatic bit eieosOn();
        return EieosEn && (mCfg.gen == 3'd3);
    endfunction

    // TS count: in an EIEOS run every 33rd handshake (starting with the first) is an EIEOS
    function automatic int expCount();
        int c;
        c = eieosOn() ? (p - (p + 32) / 33) : p;
        return (c > 2047) ? 2047 : c;
    endfunction

    function automatic logic [2047:0] expSet();
        if (mActive && eieosOn() && (p % 33 == 0)) return eieosPattern();
        return mLastTs;
    endfunction

    task automatic modelEdge();
        bit acc;
        if (reset) begin
            mLoad = 0; mActive = 0; mStopping = 0; mDone = 0; p = 0; mSub = '0;
            mCfg.gen = '0; mCfg.link = '0; mCfg.nDet = '0; mCfg.rate = '0; mCfg.tc = '0;
            mLastTs = '0;
        end else if (mActive) begin
            acc = osReady;
            if (acc) p++;
            if (acc && expCount() >= minOf(mSub)) mDone = 1;
            if (mStopping) begin
                if (acc) begin mActive = 0; mStopping = 0; end
            end else if (stop) begin
                if (acc) mActive = 0;
                else mStopping = 1;
            end
        end else if (mLoad) begin
            mLoad = 0; mActive = 1; p = 0; mDone = 0;
            mCfg.gen = gen; mCfg.link = linkNumber; mCfg.nDet = numberOfDetectedLanes;
            mCfg.rate = rateId; mCfg.tc = trainingCtrl;
            mLastTs = modelTs(mSub, mCfg);
        end else if (start && !stop && minOf(substate) != 0) begin
            mLoad = 1; mSub = substate;
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkSet(input string name, input logic [2047:0] act,
                            input logic [2047:0] exp);
        bit shown;
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            shown = 0;
            for (int i = 0; i < 16; i++) begin
                if (!shown && act[i*128 +: 128] !== exp[i*128 +: 128]) begin
                    shown = 1;
                    $display("FAIL %s lane %0d: got %h, want %h (t=%0t)", name, i,
                             act[i*128 +: 128], exp[i*128 +: 128], $time);
                end
            end
        end
    endtask

    task automatic checkAll();
        checkVal("osValid", 32'(osValid), 32'(mActive));
        checkVal("busy", 32'(busy), 32'(mActive));
        checkVal("sentCount", 32'(sentCount), 32'(expCount()));
        checkVal("minSentDone", 32'(minSentDone), 32'(mDone));
        checkSet("orderedSets", orderedSets, expSet());
    endtask

    // Advance one clock: model consumes the inputs seen at the edge, then outputs are checked
    task automatic step();
        modelEdge();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    typedef struct {
        logic [4:0] sub;
        logic [2:0] gen;
        logic [7:0] link;
        logic [4:0] nDet;
        logic [7:0] sym0;
        logic [7:0] l0Link;
        logic [7:0] l0Lane;
        logic [7:0] l3Lane;
        logic [7:0] l15Link;
        int         minCnt;
    } vecT;

    vecT vecs [7];
    int  validSubs [7];

    initial begin
        int lat, cnt, stopAt;
        bit prevHeld;
        logic [2047:0] prevSet;

        vecs[0] = '{5'd2,  3'd1, 8'h03, 5'd4,  8'hBC, 8'hF7, 8'hF7, 8'hF7, 8'hF7, 1024};
        vecs[1] = '{5'd5,  3'd1, 8'h03, 5'd4,  8'hBC, 8'h03, 8'h00, 8'h03, 8'hF7, 1};
        vecs[2] = '{5'd6,  3'd2, 8'h11, 5'd16, 8'hBC, 8'h11, 8'h00, 8'h03, 8'h11, 16};
        vecs[3] = '{5'd13, 3'd3, 8'h22, 5'd1,  8'h2D, 8'h22, 8'h00, 8'hF7, 8'hF7, 16};
        vecs[4] = '{5'd11, 3'd3, 8'h05, 5'd0,  8'h1E, 8'hF7, 8'hF7, 8'hF7, 8'hF7, 1};
        vecs[5] = '{5'd4,  3'd2, 8'h07, 5'd8,  8'hBC, 8'h07, 8'hF7, 8'hF7, 8'hF7, 1};
        vecs[6] = '{5'd3,  3'd1, 8'h09, 5'd16, 8'hBC, 8'hF7, 8'hF7, 8'hF7, 8'hF7, 16};
        validSubs = '{2, 3, 4, 5, 6, 11, 13};

        // Reset state
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checkVal("reset osValid", 32'(osValid), 32'd0);
        checkVal("reset sentCount", 32'(sentCount), 32'd0);
        checkSet("reset orderedSets", orderedSets, '0);

        // Table-driven substate vectors
        for (int v = 0; v < 7; v++) begin
            substate = vecs[v].sub; gen = vecs[v].gen; linkNumber = vecs[v].link;
            numberOfDetectedLanes = vecs[v].nDet; rateId = 8'h06; trainingCtrl = 8'h00;
            osReady = 1'b1;
            start = 1'b1; step(); start = 1'b0;
            lat = 1;
            while (!osValid && lat < 6) begin step(); lat++; end
            checkVal("start-to-valid latency", 32'(lat), 32'd2);
            cnt = 0;
            while (!minSentDone && cnt < 1200) begin step(); cnt++; end
            checkVal("minSentDone reached", 32'(minSentDone), 32'd1);
            checkVal("sentCount at minimum", 32'(sentCount), 32'(vecs[v].minCnt));
            stop = 1'b1; step(); stop = 1'b0;
            checkVal("idle after stop", 32'(busy), 32'd0);
            checkVal("lane0 sym0", 32'(orderedSets[7:0]), 32'(vecs[v].sym0));
            checkVal("lane0 link", 32'(orderedSets[15:8]), 32'(vecs[v].l0Link));
            checkVal("lane0 lane", 32'(orderedSets[23:16]), 32'(vecs[v].l0Lane));
            checkVal("lane3 lane", 32'(orderedSets[3*128+16 +: 8]), 32'(vecs[v].l3Lane));
            checkVal("lane15 link", 32'(orderedSets[15*128+8 +: 8]), 32'(vecs[v].l15Link));
            checkVal("lane0 sym4", 32'(orderedSets[39:32]), 32'h06);
        end

        // Config.Complete with osReady toggling 1010...
        substate = 5'd6; gen = 3'd1; linkNumber = 8'h0A; numberOfDetectedLanes = 5'd16;
        osReady = 1'b0;
        start = 1'b1; step(); start = 1'b0; step();
        cnt = 0;
        while (!minSentDone && cnt < 100) begin
            osReady = (cnt % 2 == 0);
            prevSet = orderedSets;
            prevHeld = osValid && !osReady;
            linkNumber = 8'(cnt);
            step();
            if (prevHeld) checkSet("held while not ready", orderedSets, prevSet);
            cnt++;
        end
        checkVal("toggle sentCount", 32'(sentCount), 32'd16);
        checkVal("toggle cycles to min", 32'(cnt), 32'd31);

        // Stop while not ready: drain keeps the set until accepted
        osReady = 1'b0; stop = 1'b1; step(); stop = 1'b0;
        checkVal("drain busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) step();
        checkVal("drain osValid held", 32'(osValid), 32'd1);
        osReady = 1'b1; step();
        checkVal("drain exit osValid", 32'(osValid), 32'd0);
        checkVal("drain counted", 32'(sentCount), 32'd17);

        // Reset mid-SEND at sentCount = 500, then an invalid substate start
        substate = 5'd2; gen = 3'd1; osReady = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        cnt = 0;
        while (sentCount != 11'd500 && cnt < 600) begin step(); cnt++; end
        checkVal("reached 500", 32'(sentCount), 32'd500);
        reset = 1'b1; step(); reset = 1'b0;
        checkVal("reset osValid mid-send", 32'(osValid), 32'd0);
        checkVal("reset sentCount mid-send", 32'(sentCount), 32'd0);
        checkVal("reset minSentDone mid-send", 32'(minSentDone), 32'd0);
        substate = 5'd9;
        start = 1'b1; step(); start = 1'b0; step(); step();
        checkVal("invalid substate stays idle", 32'(busy), 32'd0);

        // start and stop in the same cycle: stop wins
        substate = 5'd5;
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0; step(); step();
        checkVal("start+stop ignored", 32'(osValid), 32'd0);

        // Saturation of sentCount
        substate = 5'd2; gen = 3'd1; osReady = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 2060; i++) step();
        checkVal("sentCount saturates", 32'(sentCount), 32'd2047);
        checkVal("minSentDone after saturation", 32'(minSentDone), 32'd1);
        stop = 1'b1; step(); stop = 1'b0;

        // EIEOS placement at gen 3 (only with the feature built in) and never at gen 2
        for (int g = 3; g >= 2; g--) begin
            substate = 5'd13; gen = 3'(g); linkNumber = 8'h01; numberOfDetectedLanes = 5'd16;
            osReady = 1'b1;
            start = 1'b1; step(); start = 1'b0; step();
            for (int i = 0; i < 34; i++) begin
                if (EieosEn && g == 3 && (i == 0 || i == 33)) begin
                    checkVal("EIEOS sym0", 32'(orderedSets[7:0]), 32'h00);
                    checkVal("EIEOS sym1", 32'(orderedSets[15:8]), 32'hFF);
                end else begin
                    checkVal("TS2 sym0", 32'(orderedSets[7:0]), (g == 3) ? 32'h2D : 32'hBC);
                end
                step();
            end
            stop = 1'b1; step(); stop = 1'b0;
        end

        // Randomized runs against the model
        for (int r = 0; r < 25; r++) begin
            substate = ($urandom % 5 == 0) ? 5'd9 : 5'(validSubs[$urandom % 7]);
            gen = 3'($urandom_range(1, 3)); linkNumber = 8'($urandom);
            numberOfDetectedLanes = 5'($urandom); rateId = 8'($urandom);
            trainingCtrl = 8'($urandom); osReady = 1'($urandom);
            start = 1'b1; step(); start = 1'b0;
            stopAt = 1 + int'($urandom % 150);
            for (int c = 0; c < 400; c++) begin
                if (!mActive && !mLoad && c > 2) break;
                osReady = ($urandom % 10) < 7;
                stop = (c == stopAt);
                start = mActive && ($urandom % 8 == 0);
                reset = ($urandom % 300 == 0);
                if (mActive) begin
                    substate = 5'($urandom); gen = 3'($urandom_range(1, 3));
                    linkNumber = 8'($urandom); numberOfDetectedLanes = 5'($urandom);
                    rateId = 8'($urandom); trainingCtrl = 8'($urandom);
                end
                step();
            end
            start = 1'b0; stop = 1'b0; reset = 1'b0;
            checkVal("random run returns idle", 32'(busy), 32'd0);
            if (busy) begin
                reset = 1'b1; step(); reset = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/tx_os_generator.md
Name: tx_os_generator

Overview:
Transmit-side ordered-set generator for the LTSSM. It is the counterpart of the receive-side ordered-set checkers.
- Per LTSSM substate, it builds TS1/TS2 ordered sets for 16 lanes and streams them to the Tx lane datapath over a valid/ready handshake.
- It counts accepted sets and signals when the substate's minimum transmit count is met.
- It sits between the master LTSSM (substate, start/stop) and the Tx framing/scrambler stage.

Parameters:
DEVICETYPE, 0, 0 = upstream port, 1 = downstream port; only a downstream port drives non-PAD link/lane numbers in Configuration.
LANES, 16, number of lane slots generated; fixed 128 bits per lane.
NFTS, 8'd255, N_FTS value placed in symbol 3.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
substate  in  5  current LTSSM substate code
start  in  1  pulse; latch configuration and begin sending for the current substate
stop  in  1  pulse; end sending after the set currently offered is accepted
gen  in  3  current rate (1..3); selects symbol-0 encoding
linkNumber  in  8  link number to advertise
numberOfDetectedLanes  in  5  active lanes; lanes at or above this count send PAD link/lane
rateId  in  8  symbol 4 (data rate identifier)
trainingCtrl  in  8  symbol 5 (training control)
orderedSets  out  2048  lane i occupies bits [i*128+127:i*128]; symbol k at bits [k*8+7:k*8]
osValid  out  1  orderedSets valid
osReady  in  1  Tx datapath accepts the set this cycle
minSentDone  out  1  minimum count for the substate reached (sticky until next start/reset)
sentCount  out  11  accepted sets since start (saturates at 2047)
busy  out  1  generator in SEND or DRAIN

Behaviour:
- Reset (synchronous): state IDLE; osValid, minSentDone, busy = 0; sentCount = 0; orderedSets = 0.
- Substate table, latched on start:
  - 2 Polling.Active: TS1, PAD link/lane, min 1024.
  - 3 Polling.Configuration: TS2, PAD, min 16.
  - 4 Config.LinkWidthStart: TS1, link = linkNumber if DEVICETYPE else PAD, lane PAD, min 1.
  - 5 Config.LaneNumWait: TS1, link + lane = i, min 1.
  - 6 Config.Complete: TS2, link + lane, min 16.
  - 11 Recovery.RcvrLock: TS1, link + lane, min 1.
  - 13 Recovery.RcvrCfg: TS2, link + lane, min 16.
  - Any other code: start ignored, remain IDLE.
- Symbols:
  - sym0: 0xBC (COM) for gen 1/2.
  - sym0 for gen 3: 0x1E (TS1) or 0x2D (TS2).
  - sym1: link.
  - sym2: lane.
  - sym3: NFTS.
  - sym4: rateId.
  - sym5: trainingCtrl.
  - sym6–15: 0x4A (TS1) or 0x45 (TS2).
  - PAD = 0xF7.
  - In substates 4–13 with a non-PAD link, lane numbering also requires i < numberOfDetectedLanes; otherwise link and lane are PAD.
- FSM states: IDLE, LOAD, SEND, DRAIN.
  - IDLE→LOAD on start with a valid substate.
  - LOAD (1 cycle): builds orderedSets from latched inputs, clears sentCount and minSentDone → SEND.
  - SEND: osValid = 1. orderedSets and osValid are held stable while osReady = 0.
  - SEND→DRAIN on stop while osValid && !osReady.
  - SEND→IDLE on stop with osReady high the same cycle; that set counts.
  - DRAIN: osValid held until osReady, then → IDLE with osValid = 0.
- Counting:
  - sentCount increments on osValid && osReady, and saturates at 2047.
  - minSentDone rises the cycle after the accepted set that makes sentCount equal the minimum, and stays high through IDLE.
  - Latency: start at cycle t → osValid at t+2.
- Other inputs:
  - Inputs other than start, stop and osReady are sampled only in LOAD; changes mid-SEND have no effect.
  - A start in SEND or DRAIN is ignored.
  - A start in the same cycle as stop: stop wins.
- Reset mid-operation: immediate return to reset values; no partial handshake is completed.

Optional Feature:
TX_EIEOS_INSERT_EN:
- Defined: when gen == 3, the generator sends one EIEOS (all 16 symbols alternate 0x00/0xFF per symbol, starting 0x00) before the first TS and after every 32 accepted TS sets. EIEOS is not counted in sentCount.
- Undefined: no EIEOS is ever generated; the logic is absent.

Test Plan:
- Substate 2, gen 1, start, osReady = 1 constantly → osValid at t+2; all lanes sym0 = 0xBC, sym1/sym2 = 0xF7, sym6–15 = 0x4A; minSentDone rises after accepted set 1024.
- Substate 5, DEVICETYPE = 1, linkNumber = 0x03, numberOfDetectedLanes = 4 → lanes 0–3 sym1 = 0x03, sym2 = 0..3; lanes 4–15 sym1/sym2 = 0xF7.
- Substate 6, osReady toggled 1010… → orderedSets stable while not ready; minSentDone after exactly 16 accepted sets; sentCount = 16.
- stop asserted while osValid = 1, osReady = 0 → DRAIN; set held until osReady, then IDLE; sentCount includes that set.
- Reset asserted mid-SEND at sentCount = 500 → next cycle osValid = 0, sentCount = 0, minSentDone = 0; start with substate 9 → remains IDLE.
- TX_EIEOS_INSERT_EN defined, gen 3, substate 13 → EIEOS, 32 TS2 (sym0 = 0x2D), EIEOS; minSentDone after 16 TS2; with gen 2 → no EIEOS.
